// File: rtl/riscv_rf_pkg.sv
// Shared constants for the RISC-V integer register file: special register
// indices, default geometry and the stack-pointer reset value.
package riscv_rf_pkg;

    localparam int REG_ZERO     = 0;
    localparam int REG_SP       = 2;
    localparam int RF_ADDR_BITS = 5;
    localparam int RF_DATA_BITS = 32;

    localparam logic [RF_DATA_BITS-1:0] SP_RESET_VALUE = 32'h0000_3FFC;

    // Reset image of one architectural register.
    function automatic logic [RF_DATA_BITS-1:0] reg_reset_value(
        input int                       idx,
        input logic [RF_DATA_BITS-1:0]  sp_init
    );
        return (idx == REG_SP) ? sp_init : '0;
    endfunction

endpackage

// File: rtl/rf_word.sv
// One register-file word: load-enabled register with asynchronous
// active-high reset to a per-instance value.
module rf_word #(
    parameter int                    NrOfBits   = 32,
    parameter logic [NrOfBits-1:0]   ResetValue = '0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Load,
    input  logic [NrOfBits-1:0]   D,
    output logic [NrOfBits-1:0]   Q
);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Q <= ResetValue;
        end else if (Load) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/riscv_register_file.sv
// 32-entry RISC-V integer register file: x0 reads zero, x2 resets to StackInit.
// Optional same-cycle write-to-read forwarding with REGFILE_WRITE_BYPASS_EN.
module riscv_register_file
    import riscv_rf_pkg::*;
#(
    parameter int                    NrOfBits  = RF_DATA_BITS,
    parameter int                    NrOfRegs  = 32,
    parameter int                    AddrBits  = RF_ADDR_BITS,
    parameter logic [NrOfBits-1:0]   StackInit = SP_RESET_VALUE
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ClockEnable,
    input  logic                  Tick,
    input  logic                  WriteEnable,
    input  logic [AddrBits-1:0]   WriteAddr,
    input  logic [NrOfBits-1:0]   WriteData,
    input  logic [AddrBits-1:0]   ReadAddrA,
    input  logic [AddrBits-1:0]   ReadAddrB,
    output logic [NrOfBits-1:0]   ReadDataA,
    output logic [NrOfBits-1:0]   ReadDataB,
    input  logic [AddrBits-1:0]   DebugAddr,
    output logic [NrOfBits-1:0]   DebugData
);

    logic [NrOfBits-1:0] regs [NrOfRegs];
    logic                write_fire;
    logic [AddrBits-1:0] rd_addr [3];
    logic [NrOfBits-1:0] rd_data [3];

    assign write_fire = ~Reset & ClockEnable & Tick & WriteEnable &
                        (WriteAddr != AddrBits'(REG_ZERO));

    // x0 has no storage; the slot is tied off so the array is fully driven.
    assign regs[0] = '0;

    for (genvar i = 1; i < NrOfRegs; i++) begin : g_word
        logic load_word;
        assign load_word = write_fire && (WriteAddr == AddrBits'(i));

        rf_word #(
            .NrOfBits   (NrOfBits),
            .ResetValue (reg_reset_value(i, StackInit))
        ) u_word (
            .Clock (Clock),
            .Reset (Reset),
            .Load  (load_word),
            .D     (WriteData),
            .Q     (regs[i])
        );
    end

    assign rd_addr[0] = ReadAddrA;
    assign rd_addr[1] = ReadAddrB;
    assign rd_addr[2] = DebugAddr;

    // Port order: A, B, debug. x0 override is applied last so it beats forwarding.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_data[p] = regs[rd_addr[p]];
`ifdef REGFILE_WRITE_BYPASS_EN
            if (write_fire && (rd_addr[p] == WriteAddr)) begin
                rd_data[p] = WriteData;
            end
`endif
            if (rd_addr[p] == AddrBits'(REG_ZERO)) begin
                rd_data[p] = '0;
            end
        end
    end

    assign ReadDataA = rd_data[0];
    assign ReadDataB = rd_data[1];
    assign DebugData = rd_data[2];

endmodule
